// File: rtl/alarm_controller.sv
// alarm_controller
//   Alarm block for the century clock. Compares the live hour/min/sec from the
//   time counters against a stored alarm time. On a match it rings, and it
//   supports snooze with a limited retry count, stop, auto-timeout and
//   button-driven setting through the shared mode selector.
//   Runs on the 1 Hz tick.
//
// Ports
//   clk_1Hz     in   1  1 Hz clock, rising edge
//   rst_n       in   1  synchronous active-low reset
//   sec/min     in   6  current seconds / minutes (0..59)
//   hour        in   5  current hour (0..23)
//   mode        in   3  global mode selector
//   btn_up      in   1  active-low increment (acts every edge held)
//   btn_down    in   1  active-low decrement
//   btn_snooze  in   1  active-low snooze request
//   btn_stop    in   1  active-low stop request
//   alarm_en    in   1  1 = armed, 0 forces IDLE
//   alarm_hour  out  5  stored alarm hour
//   alarm_min   out  6  stored alarm minute
//   ringing     out  1  high while ringing
//   snoozing    out  1  high while snoozing
//   snooze_cnt  out  3  snoozes used in the current alarm event
module alarm_controller #(
  parameter logic [2:0]  SET_HOUR_MODE = 3'b011,
  parameter logic [2:0]  SET_MIN_MODE  = 3'b100,
  parameter int unsigned RING_SECS     = 60,
  parameter int unsigned SNOOZE_SECS   = 300,
  parameter int unsigned MAX_SNOOZE    = 3
) (
  input  logic       clk_1Hz,
  input  logic       rst_n,
  input  logic [5:0] sec,
  input  logic [5:0] min,
  input  logic [4:0] hour,
  input  logic [2:0] mode,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_snooze,
  input  logic       btn_stop,
  input  logic       alarm_en,
  output logic [4:0] alarm_hour,
  output logic [5:0] alarm_min,
  output logic       ringing,
  output logic       snoozing,
  output logic [2:0] snooze_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RINGING,
    S_SNOOZE
  } state_t;

  localparam logic [9:0] RING_LOAD   = 10'(RING_SECS - 1);
  localparam logic [9:0] SNOOZE_LOAD = 10'(SNOOZE_SECS - 1);
  localparam logic [2:0] MAX_CNT     = 3'(MAX_SNOOZE);

  state_t     state, state_nxt;
  logic [9:0] timer, timer_nxt;
  logic [2:0] cnt_nxt;
  logic [4:0] hour_nxt;
  logic [5:0] min_nxt;
  logic       set_hour, set_min, in_set, time_match;

  assign set_hour   = (mode == SET_HOUR_MODE);
  assign set_min    = (mode == SET_MIN_MODE);
  assign in_set     = set_hour || set_min;
  assign time_match = (sec == 6'd0) && (min == alarm_min) && (hour == alarm_hour);

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    cnt_nxt   = snooze_cnt;
    hour_nxt  = alarm_hour;
    min_nxt   = alarm_min;

    // Alarm time adjustment; up has priority over down.
    if (set_hour) begin
      if (!btn_up)
        hour_nxt = (alarm_hour == 5'd23) ? 5'd0 : alarm_hour + 5'd1;
      else if (!btn_down)
        hour_nxt = (alarm_hour == 5'd0) ? 5'd23 : alarm_hour - 5'd1;
    end
    if (set_min) begin
      if (!btn_up)
        min_nxt = (alarm_min == 6'd59) ? 6'd0 : alarm_min + 6'd1;
      else if (!btn_down)
        min_nxt = (alarm_min == 6'd0) ? 6'd59 : alarm_min - 6'd1;
    end

    if (in_set || !alarm_en) begin
      state_nxt = S_IDLE;
      cnt_nxt   = '0;
      timer_nxt = '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (time_match) begin
            state_nxt = S_RINGING;
            timer_nxt = RING_LOAD;
          end
        end
        S_RINGING: begin
          if (!btn_stop) begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
            timer_nxt = '0;
          end else if (!btn_snooze && (snooze_cnt < MAX_CNT)) begin
            state_nxt = S_SNOOZE;
            timer_nxt = SNOOZE_LOAD;
            cnt_nxt   = snooze_cnt + 3'd1;
          end else if (timer == '0) begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
          end else begin
            timer_nxt = timer - 10'd1;
          end
        end
        S_SNOOZE: begin
          if (!btn_stop) begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
            timer_nxt = '0;
          end else if (timer == '0) begin
            state_nxt = S_RINGING;
            timer_nxt = RING_LOAD;
          end else begin
            timer_nxt = timer - 10'd1;
          end
        end
        default: begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
          timer_nxt = '0;
        end
      endcase
    end
  end

  // ringing/snoozing are decoded from the next state so they are flops
  // that change on the same edge as the state itself.
  always_ff @(posedge clk_1Hz) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      timer      <= '0;
      snooze_cnt <= '0;
      alarm_hour <= 5'd6;
      alarm_min  <= '0;
      ringing    <= 1'b0;
      snoozing   <= 1'b0;
    end else begin
      state      <= state_nxt;
      timer      <= timer_nxt;
      snooze_cnt <= cnt_nxt;
      alarm_hour <= hour_nxt;
      alarm_min  <= min_nxt;
      ringing    <= (state_nxt == S_RINGING);
      snoozing   <= (state_nxt == S_SNOOZE);
    end
  end

endmodule

// File: tb/tb_alarm_controller.sv
// Testbench for alarm_controller: directed steps followed by a random phase,
// all checked against a countdown-based reference model of the alarm rules.
module tb_alarm_controller;

  localparam logic [2:0] HMODE  = 3'b011;
  localparam logic [2:0] MMODE  = 3'b100;
  localparam int         RING   = 60;
  localparam int         SNOOZE = 300;
  localparam int         MAXS   = 3;

  logic       clk_1Hz = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] sec = '0, min = '0;
  logic [4:0] hour = '0;
  logic [2:0] mode = '0;
  logic       btn_up = 1'b1, btn_down = 1'b1, btn_snooze = 1'b1, btn_stop = 1'b1;
  logic       alarm_en = 1'b0;
  logic [4:0] alarm_hour;
  logic [5:0] alarm_min;
  logic       ringing, snoozing;
  logic [2:0] snooze_cnt;

  alarm_controller #(
    .SET_HOUR_MODE(HMODE),
    .SET_MIN_MODE (MMODE),
    .RING_SECS    (RING),
    .SNOOZE_SECS  (SNOOZE),
    .MAX_SNOOZE   (MAXS)
  ) dut (
    .clk_1Hz   (clk_1Hz),
    .rst_n     (rst_n),
    .sec       (sec),
    .min       (min),
    .hour      (hour),
    .mode      (mode),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .btn_snooze(btn_snooze),
    .btn_stop  (btn_stop),
    .alarm_en  (alarm_en),
    .alarm_hour(alarm_hour),
    .alarm_min (alarm_min),
    .ringing   (ringing),
    .snoozing  (snoozing),
    .snooze_cnt(snooze_cnt)
  );

  always #5 clk_1Hz = ~clk_1Hz;

  int n_cmp = 0;
  int n_fail = 0;
  int tsec = 0;

  // Reference model: remaining ring / snooze edges instead of a state machine.
  int m_hr = 6, m_mn = 0, m_ring_left = 0, m_snz_left = 0, m_used = 0;

  task automatic model_step();
    if (!rst_n) begin
      m_hr = 6; m_mn = 0; m_ring_left = 0; m_snz_left = 0; m_used = 0;
    end else begin
      if (mode == HMODE) begin
        if (!btn_up) m_hr = (m_hr + 1) % 24;
        else if (!btn_down) m_hr = (m_hr + 23) % 24;
      end
      if (mode == MMODE) begin
        if (!btn_up) m_mn = (m_mn + 1) % 60;
        else if (!btn_down) m_mn = (m_mn + 59) % 60;
      end
      if (mode == HMODE || mode == MMODE || !alarm_en) begin
        m_ring_left = 0; m_snz_left = 0; m_used = 0;
      end else if (m_ring_left > 0) begin
        if (!btn_stop) begin
          m_ring_left = 0; m_used = 0;
        end else if (!btn_snooze && m_used < MAXS) begin
          m_ring_left = 0; m_snz_left = SNOOZE; m_used++;
        end else begin
          m_ring_left--;
          if (m_ring_left == 0) m_used = 0;
        end
      end else if (m_snz_left > 0) begin
        if (!btn_stop) begin
          m_snz_left = 0; m_used = 0;
        end else begin
          m_snz_left--;
          if (m_snz_left == 0) m_ring_left = RING;
        end
      end else if (int'(sec) == 0 && int'(min) == m_mn && int'(hour) == m_hr) begin
        m_ring_left = RING;
      end
    end
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive_time();
    hour = 5'(tsec / 3600);
    min  = 6'((tsec / 60) % 60);
    sec  = 6'(tsec % 60);
  endtask

  task automatic set_time(input int h, input int m, input int s);
    tsec = ((h * 3600 + m * 60 + s) % 86400 + 86400) % 86400;
    drive_time();
  endtask

  // One clock edge: model steps on the edge, outputs are checked 1 time unit later,
  // then the wall clock advances by one second.
  task automatic cyc();
    @(posedge clk_1Hz);
    model_step();
    #1;
    check("alarm_hour", int'(alarm_hour), m_hr);
    check("alarm_min",  int'(alarm_min),  m_mn);
    check("ringing",    int'(ringing),    int'(m_ring_left > 0));
    check("snoozing",   int'(snoozing),   int'(m_snz_left > 0));
    check("snooze_cnt", int'(snooze_cnt), m_used);
    tsec = (tsec + 1) % 86400;
    drive_time();
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycles(2);
    rst_n = 1'b1;
  endtask

  int cnt;

  initial begin
    #1;
    // Reset state
    do_reset();
    check("rst_hour", int'(alarm_hour), 6);
    check("rst_ring", int'(ringing), 0);

    // Hour setting: 18 ups wrap 6 -> 0, one down wraps 0 -> 23, both -> up wins
    mode = HMODE; btn_up = 1'b0;
    cycles(18);
    check("hour_wrap_up", int'(alarm_hour), 0);
    btn_up = 1'b1; btn_down = 1'b0;
    cycles(1);
    check("hour_wrap_down", int'(alarm_hour), 23);
    btn_up = 1'b0;
    cycles(1);
    check("hour_up_prio", int'(alarm_hour), 0);
    // Minute setting wrap down 0 -> 59, then up 59 -> 0
    mode = MMODE; btn_up = 1'b1;
    cycles(1);
    check("min_wrap_down", int'(alarm_min), 59);
    btn_up = 1'b0;
    cycles(1);
    check("min_wrap_up", int'(alarm_min), 0);
    btn_up = 1'b1; btn_down = 1'b1; mode = '0;
    do_reset();

    // Ring for exactly RING edges at 06:00:00, no retrigger
    alarm_en = 1'b1;
    set_time(5, 59, 58);
    cnt = 0;
    for (int i = 0; i < 140; i++) begin
      cyc();
      if (ringing) cnt++;
    end
    check("ring_len", cnt, RING);

    // Snooze three times, each snooze lasting SNOOZE edges
    set_time(6, 0, 0);
    cycles(5);
    for (int k = 1; k <= MAXS; k++) begin
      btn_snooze = 1'b0;
      cyc();
      btn_snooze = 1'b1;
      check("snooze_cnt_step", int'(snooze_cnt), k);
      cnt = 1;
      for (int i = 0; i < SNOOZE + 4; i++) begin
        cyc();
        if (snoozing) cnt++;
      end
      check("snooze_len", cnt, SNOOZE);
      check("ring_after_snooze", int'(ringing), 1);
    end
    // Fourth snooze ignored, then stop beats snooze
    btn_snooze = 1'b0;
    cyc();
    check("snooze_limit_ring", int'(ringing), 1);
    check("snooze_limit_cnt", int'(snooze_cnt), MAXS);
    btn_stop = 1'b0;
    cyc();
    btn_stop = 1'b1; btn_snooze = 1'b1;
    check("stop_ring", int'(ringing), 0);
    check("stop_cnt", int'(snooze_cnt), 0);
    cycles(5);

    // Set mode while ringing forces IDLE
    set_time(6, 0, 0);
    cycles(3);
    mode = MMODE;
    cyc();
    mode = '0;
    check("setmode_idle", int'(ringing), 0);
    cycles(3);

    // alarm_en low while snoozing forces IDLE and clears count
    set_time(6, 0, 0);
    cycles(3);
    btn_snooze = 1'b0;
    cyc();
    btn_snooze = 1'b1;
    cycles(4);
    alarm_en = 1'b0;
    cyc();
    alarm_en = 1'b1;
    check("en_off_snooze", int'(snoozing), 0);
    check("en_off_cnt", int'(snooze_cnt), 0);

    // Random phase
    for (int i = 0; i < 4000; i++) begin
      int r;
      r = $urandom_range(0, 999);
      if (r < 15) mode = HMODE;
      else if (r < 30) mode = MMODE;
      else if (r < 40) mode = 3'($urandom_range(0, 7));
      else mode = '0;
      btn_up     = ($urandom_range(0, 3) != 0);
      btn_down   = ($urandom_range(0, 3) != 0);
      btn_snooze = ($urandom_range(0, 19) != 0);
      btn_stop   = ($urandom_range(0, 149) != 0);
      alarm_en   = ($urandom_range(0, 99) != 0);
      rst_n      = ($urandom_range(0, 999) != 0);
      if ($urandom_range(0, 199) == 0)
        set_time(m_hr, m_mn, -int'($urandom_range(0, 3)));
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
